// File: rtl/score_grader.sv
// Rhythm-game note grader: counts judged notes during a run, grades on song end.
// Optional per-user/per-song best-grade table enabled by defining BEST_SCORE_EN.
module score_grader #(
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       note_valid,
    input  logic       note_hit,
    input  logic       song_end,
    input  logic       user,
    input  logic [3:0] song,
    output logic [3:0] score,
    output logic [3:0] score_user,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam int              PW      = CNT_W + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic [3:0]       score_q, score_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    function automatic logic [3:0] grade(input logic [CNT_W-1:0] t, input logic [CNT_W-1:0] h);
        logic [PW-1:0] t_w;
        logic [PW-1:0] h_w;
        t_w = PW'(t);
        h_w = PW'(h);
        if (t == '0)                                grade = 4'b0000;
        else if (h_w * PW'(8) >= t_w * PW'(7))      grade = 4'b1000;
        else if (h_w * PW'(4) >= t_w * PW'(3))      grade = 4'b0100;
        else if (h_w * PW'(2) >= t_w)               grade = 4'b0010;
        else                                        grade = 4'b0001;
    endfunction

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        hits_d  = hits_q;
        score_d = score_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PLAY;
                    total_d = '0;
                    hits_d  = '0;
                    score_d = 4'b0000;
                end
            end
            PLAY: begin
                if (start) begin
                    total_d = '0;
                    hits_d  = '0;
                    score_d = 4'b0000;
                end else begin
                    // A note on the song_end cycle is folded in before grading.
                    if (note_valid && total_q != CNT_MAX) begin
                        total_d = total_q + 1'b1;
                        if (note_hit) hits_d = hits_q + 1'b1;
                    end
                    if (song_end) begin
                        state_d = DONE;
                        score_d = grade(total_d, hits_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_q == PLAY) && (state_d == DONE);
        busy_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            total_q <= '0;
            hits_q  <= '0;
            score_q <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            hits_q  <= hits_d;
            score_q <= score_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign score = score_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef BEST_SCORE_EN
    function automatic logic [2:0] rank(input logic [3:0] g);
        case (g)
            4'b1000: rank = 3'd4;
            4'b0100: rank = 3'd3;
            4'b0010: rank = 3'd2;
            4'b0001: rank = 3'd1;
            default: rank = 3'd0;
        endcase
    endfunction

    logic [31:0] best_flat;
    logic [2:0]  tbl_idx;
    logic [3:0]  cur_best;
    logic        song_in_tbl;
    logic        wr_en;
    logic [3:0]  score_user_q, score_user_d;

    assign tbl_idx     = {user, song[1:0]};
    assign song_in_tbl = (song[3:2] == 2'b00);
    assign cur_best    = best_flat[{tbl_idx, 2'b00} +: 4];
    assign wr_en       = done_d && song_in_tbl && (rank(score_d) > rank(cur_best));

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_best
            logic [3:0] entry_q, entry_d;
            always_comb begin
                entry_d = entry_q;
                if (wr_en && tbl_idx == 3'(gi)) entry_d = score_d;
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) entry_q <= 4'b0000;
                else       entry_q <= entry_d;
            end
            assign best_flat[gi*4 +: 4] = entry_q;
        end
    endgenerate

    always_comb begin
        score_user_d = song_in_tbl ? cur_best : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) score_user_q <= 4'b0000;
        else       score_user_q <= score_user_d;
    end

    assign score_user = score_user_q;
`else
    logic unused_sel;
    assign unused_sel = ^{user, song};
    assign score_user = score_q;
`endif

endmodule

// File: tb/tb_score_grader.sv
// Self-checking bench for score_grader: graded-run vector table plus hand-written
// corner sequences; expected grades flow through a scoreboard queue.
module tb_score_grader;

    logic       clk = 1'b0;
    logic       reset, start, note_valid, note_hit, song_end, user;
    logic [3:0] song;
    logic [3:0] score, score_user;
    logic       busy, done;

    always #5 clk = ~clk;

    score_grader #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .note_valid (note_valid),
        .note_hit   (note_hit),
        .song_end   (song_end),
        .user       (user),
        .song       (song),
        .score      (score),
        .score_user (score_user),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int         n;
        int         h;
        bit         end_note;
        bit         end_hit;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [12];
    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic play_notes(input int n, input int h);
        for (int i = 0; i < n; i++) begin
            note_valid = 1'b1;
            note_hit   = (i < h);
            tick();
        end
        note_valid = 1'b0;
        note_hit   = 1'b0;
    endtask

    task automatic end_song(input bit en_note, input bit en_hit, input logic [3:0] exp);
        note_valid = en_note;
        note_hit   = en_hit;
        song_end   = 1'b1;
        exp_q.push_back(exp);
        tick();
        song_end   = 1'b0;
        note_valid = 1'b0;
        note_hit   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int         k;
        logic [3:0] e;
        k = 0;
        while (!done && k < 4) begin
            tick();
            k++;
        end
        chk({name, " done_latency"}, k, 0);
        if (exp_q.size() == 0) begin
            chk({name, " scoreboard_empty"}, 1, 0);
            e = 4'b0000;
        end else begin
            e = exp_q.pop_front();
        end
        chk({name, " score"}, int'(score), int'(e));
        chk({name, " busy_low"}, int'(busy), 0);
`ifndef BEST_SCORE_EN
        chk({name, " score_user"}, int'(score_user), int'(e));
`endif
        tick();
        chk({name, " done_one_cycle"}, int'(done), 0);
        chk({name, " score_hold"}, int'(score), int'(e));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8, 8, 1'b0, 1'b0, 4'b1000};
        vecs[1]  = '{8, 6, 1'b0, 1'b0, 4'b0100};
        vecs[2]  = '{8, 4, 1'b0, 1'b0, 4'b0010};
        vecs[3]  = '{8, 3, 1'b0, 1'b0, 4'b0001};
        vecs[4]  = '{0, 0, 1'b0, 1'b0, 4'b0000};
        vecs[5]  = '{0, 0, 1'b1, 1'b1, 4'b1000};
        vecs[6]  = '{0, 0, 1'b1, 1'b0, 4'b0001};
        vecs[7]  = '{7, 6, 1'b1, 1'b1, 4'b1000};
        vecs[8]  = '{7, 6, 1'b0, 1'b0, 4'b0100};
        vecs[9]  = '{2, 1, 1'b0, 1'b0, 4'b0010};
        vecs[10] = '{3, 1, 1'b0, 1'b0, 4'b0001};
        vecs[11] = '{4, 3, 1'b0, 1'b0, 4'b0100};

        reset = 1'b1; start = 1'b0; note_valid = 1'b0; note_hit = 1'b0;
        song_end = 1'b0; user = 1'b0; song = 4'd0;
        tick();
        tick();
        chk("reset score", int'(score), 0);
        chk("reset score_user", int'(score_user), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        reset = 1'b0;
        tick();

        // Stimulus while IDLE must be ignored.
        note_valid = 1'b1; note_hit = 1'b1; song_end = 1'b1;
        tick();
        note_valid = 1'b0; note_hit = 1'b0; song_end = 1'b0;
        chk("idle done", int'(done), 0);
        chk("idle busy", int'(busy), 0);

        for (int v = 0; v < 12; v++) begin
            do_start();
            chk($sformatf("vec%0d busy_high", v), int'(busy), 1);
            chk($sformatf("vec%0d score_cleared", v), int'(score), 0);
            play_notes(vecs[v].n, vecs[v].h);
            end_song(vecs[v].end_note, vecs[v].end_hit, vecs[v].exp);
            wait_done($sformatf("vec%0d", v));
        end

        // Restart in PLAY after 3 misses; stale counters would grade B.
        do_start();
        play_notes(3, 0);
        do_start();
        chk("restart busy", int'(busy), 1);
        play_notes(8, 8);
        end_song(1'b0, 1'b0, 4'b1000);
        wait_done("restart");

        // start with coincident song_end in PLAY: restart wins, song_end ignored.
        do_start();
        play_notes(2, 2);
        start = 1'b1; song_end = 1'b1;
        tick();
        start = 1'b0; song_end = 1'b0;
        chk("start_vs_end busy", int'(busy), 1);
        chk("start_vs_end done", int'(done), 0);
        play_notes(2, 0);
        end_song(1'b0, 1'b0, 4'b0001);
        wait_done("start_vs_end");

        // Saturation: 300 hits, then 45 misses followed by 255 hits.
        do_start();
        play_notes(300, 300);
        end_song(1'b0, 1'b0, 4'b1000);
        wait_done("sat_all_hit");
        do_start();
        play_notes(45, 0);
        play_notes(255, 255);
        end_song(1'b0, 1'b0, 4'b0100);
        wait_done("sat_mixed");

        // Asynchronous reset mid-run discards the run.
        user = 1'b1; song = 4'd1;
        do_start();
        play_notes(5, 5);
        #2 reset = 1'b1;
        #1;
        chk("midreset score", int'(score), 0);
        chk("midreset score_user", int'(score_user), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset done", int'(done), 0);
        reset = 1'b0;
        tick();
        song_end = 1'b1;
        tick();
        song_end = 1'b0;
        chk("post_reset done", int'(done), 0);
        chk("post_reset busy", int'(busy), 0);
        tick();
        chk("post_reset score_user", int'(score_user), 0);

`ifdef BEST_SCORE_EN
        user = 1'b1; song = 4'd2;
        tick();
        chk("best initial", int'(score_user), 0);
        do_start();
        play_notes(8, 6);
        end_song(1'b0, 1'b0, 4'b0100);
        wait_done("best_a");
        tick();
        chk("best after A", int'(score_user), 4'b0100);
        do_start();
        play_notes(8, 3);
        end_song(1'b0, 1'b0, 4'b0001);
        wait_done("best_c");
        tick();
        chk("best after C", int'(score_user), 4'b0100);
        user = 1'b0;
        tick();
        chk("best user0", int'(score_user), 0);
        user = 1'b1;
        tick();
        chk("best user1 back", int'(score_user), 4'b0100);
        song = 4'd6;
        tick();
        chk("best song6", int'(score_user), 0);
        song = 4'd2;
        do_start();
        play_notes(8, 8);
        end_song(1'b0, 1'b0, 4'b1000);
        wait_done("best_s");
        tick();
        chk("best after S", int'(score_user), 4'b1000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
